booth_mul_8bit: RTL and testbench

Sequential signed 8x8 radix-2 Booth multiplier for the 8-bit ALU's multiply operation. Each add/subtract step runs through one instantiated cla_8bit. The block drives the adder's A, B and Cin inputs and consumes its Sum and Cout. It sits beside the ALU operand path, takes a start pulse with two operands, and returns a 16-bit signed product after a fixed 8-cycle iteration.

---
 rtl/booth_mul_8bit.sv | 150 +++++++++++++++
 tb/tb_booth_mul_8bit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_8bit.sv
// Sequential signed 8x8 radix-2 Booth multiplier with a 16-bit product.
// Each iteration runs one add/subtract/pass step through a cla_8bit adder.

module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Carry into bit n, expanded as a flat sum of generate/propagate products.
    function automatic logic lookahead(input logic [7:0] gv, input logic [7:0] pv,
                                       input logic c0, input int n);
        logic r;
        logic pp;
        r  = 1'b0;
        pp = 1'b1;
        for (int j = 7; j >= 0; j--) begin
            if (j < n) begin
                r  = r | (pp & gv[j]);
                pp = pp & pv[j];
            end
        end
        return r | (pp & c0);
    endfunction

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    for (genvar i = 1; i <= 8; i++) begin : g_carry
        assign c[i] = lookahead(g, p, cin, i);
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];
endmodule

module booth_mul_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state_q;
    logic [7:0]  m_q;
    logic [7:0]  acc_q;
    logic [7:0]  q_q;
    logic        q1_q;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] product_q;

    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        s8;
    logic [7:0]  acc_d;
    logic [7:0]  q_d;

    always_comb begin
        add_b   = 8'h00;
        add_cin = 1'b0;
        case ({q_q[0], q1_q})
            2'b01: begin
                add_b   = m_q;
                add_cin = 1'b0;
            end
            2'b10: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            default: begin
                add_b   = 8'h00;
                add_cin = 1'b0;
            end
        endcase
    end

    cla_8bit u_cla (
        .a    (acc_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Ninth sum bit of the sign-extended add; needed when M = -128.
    assign s8    = acc_q[7] ^ add_b[7] ^ add_cout;
    assign acc_d = {s8, add_sum[7:1]};
    assign q_d   = {add_sum[0], q_q[7:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 8'h00;
            acc_q     <= 8'h00;
            q_q       <= 8'h00;
            q1_q      <= 1'b0;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= a;
                        acc_q   <= 8'h00;
                        q_q     <= b;
                        q1_q    <= 1'b0;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    q1_q  <= q_q[0];
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        product_q <= {acc_d, q_d};
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_booth_mul_8bit.sv
// Scoreboard bench for booth_mul_8bit: drivers push expected signed products,
// a negedge monitor pops them on every done pulse and checks timing and holds.

module tb_booth_mul_8bit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic [15:0] exp_q[$];
    int          acc_cyc_q[$];
    logic [15:0] held_exp;
    int          n_checks;
    int          n_pass;
    int          cyc;
    int          busy_run;
    int          accepts;
    int          abandoned;
    int          done_cnt;
    int          done_prev;
    int          done_last;

    booth_mul_8bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain signed multiply of the two operands.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] r;
        r = 16'($signed(x) * $signed(y));
        return r;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0] e;
        int c;
        cyc++;
        if (!rst_n) begin
            abandoned += exp_q.size();
            exp_q.delete();
            acc_cyc_q.delete();
            held_exp = 16'h0000;
            busy_run = 0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = acc_cyc_q.pop_front();
                    check("product", int'(product), int'(e));
                    check("latency", cyc - c, 8);
                    check("busy_cycles", busy_run, 8);
                    check("busy_at_done", int'(busy), 0);
                    held_exp = e;
                    done_cnt++;
                    done_prev = done_last;
                    done_last = cyc;
                end
                busy_run = 0;
            end else begin
                check("product_hold", int'(product), int'(held_exp));
                if (busy) busy_run++;
                else busy_run = 0;
            end
            if (start && !busy) begin
                exp_q.push_back(ref_mul(a, b));
                acc_cyc_q.push_back(cyc + 1);
                accepts++;
            end
        end
    end

    // Driver tasks; inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (n) step();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_product", int'(product), 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 40) begin
            step();
            w++;
        end
        if (busy) check("idle_wait", int'(busy), 0);
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
        wait_idle();
        a     = ia;
        b     = ib;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 60) begin
            step();
            w++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    logic [7:0] dir_a[6];
    logic [7:0] dir_b[6];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        held_exp = 16'h0000;
        dir_a = '{8'd3, 8'h80, 8'h80, 8'hFF, 8'd127, 8'd0};
        dir_b = '{8'd5, 8'h80, 8'd127, 8'd1, 8'hFF, 8'hB3};

        step();
        do_reset(2);

        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i]);
            drain();
        end

        // Starts during a busy operation must be ignored.
        issue(8'd20, 8'hFD);
        step();
        a = 8'd99; b = 8'd55; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 8'h81; b = 8'h7F; start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Start held through the done cycle: second op begins immediately.
        a = 8'd11; b = 8'hFA; start = 1'b1;
        step();
        a = 8'h9C; b = 8'd3;
        repeat (17) step();
        start = 1'b0;
        drain();
        check("b2b_period", done_last - done_prev, 9);

        // Reset in the middle of an operation, then a normal operation.
        issue(8'd45, 8'hF7);
        repeat (4) step();
        do_reset(2);
        issue(8'hF9, 8'd9);
        drain();

        for (int i = 0; i < 1000; i++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) step();
        end
        drain();

        check("done_per_accept", done_cnt, accepts - abandoned);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
